rr_mux_pipe: RTL and testbench

RR_MUX_PIPE -- requirements
Module: rr_mux_pipe

---
 rtl/rr_mux_pkg.sv | 16 +
 rtl/rr_mux_pipe_arbiter.sv | 37 +++
 rtl/rr_mux_pipe.sv | 104 ++++++++++
 tb/tb_rr_mux_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg
//   Shared defaults and helpers for the rr_mux_pipe block.
//   DEF_WIDTH  : default data width per channel
//   DEF_NUM_IN : default number of input channels
//   sel_w()    : channel index width for a given channel count
package rr_mux_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NUM_IN = 4;

    // A single-channel mux still needs a 1-bit index to keep port widths legal.
    function automatic int sel_w(input int num_in);
        return (num_in > 1) ? $clog2(num_in) : 1;
    endfunction

endpackage

// File: rtl/rr_mux_pipe_arbiter.sv
// rr_arbiter
//   Combinational round-robin grant. Priority starts at ptr+1 and wraps
//   modulo NUM_IN; the first requesting channel wins. With no request the
//   grant defaults to ptr+1.
//   Ports:
//     req   : per-channel request (in_valid)
//     ptr   : last granted channel
//     grant : granted channel index
//   Only instantiated by rr_mux_pipe when RR_MUX_RR_ARB_EN is defined.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int SEL_W  = sel_w(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  grant
);

    logic [SEL_W-1:0] w_idx;

    // Walk from the lowest priority (ptr itself) up to the highest (ptr+1)
    // so the last hit written is the highest-priority requester. NUM_IN is a
    // power of two, so index wrap is plain SEL_W-bit overflow.
    always_comb begin
        grant = ptr + SEL_W'(1);
        w_idx = '0;
        for (int i = NUM_IN; i >= 1; i--) begin
            w_idx = ptr + SEL_W'(i);
            if (req[w_idx]) begin
                grant = w_idx;
            end
        end
    end

endmodule

// File: rtl/rr_mux_pipe.sv
// rr_mux_pipe
//   N:1 multiplexer with a single registered output stage and valid/ready
//   handshakes on both sides. One channel is granted per cycle; the granted
//   channel sees in_ready whenever the output register is empty or being
//   drained on the same edge, giving one word per cycle sustained.
//
//   Configuration macro: RR_MUX_RR_ARB_EN
//     defined   : round-robin grant via rr_arbiter, sel ignored
//     undefined : grant is the fixed sel input
//
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset
//     in_data   : NUM_IN packed channels, channel k at [k*WIDTH +: WIDTH]
//     in_valid  : per-channel valid
//     in_ready  : per-channel accept (one-hot or zero)
//     sel       : fixed channel select (non round-robin build only)
//     out_data  : registered selected word
//     out_valid : out_data holds an unconsumed word
//     out_ready : downstream accept
//     out_src   : channel index out_data came from
module rr_mux_pipe
    import rr_mux_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int SEL_W  = sel_w(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_out_src;

    logic [SEL_W-1:0]  w_grant;
    logic              w_accept;
    logic              w_in_xfer;
    logic [NUM_IN-1:0] w_onehot;

`ifdef RR_MUX_RR_ARB_EN
    logic [SEL_W-1:0]  r_ptr;
    logic              w_unused_sel;

    assign w_unused_sel = ^sel;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req    (in_valid),
        .ptr    (r_ptr),
        .grant  (w_grant)
    );

    // Reset value NUM_IN-1 makes channel 0 the first in priority order.
    // The pointer only moves on an accepted word so an idle or stalled
    // channel does not lose its turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= SEL_W'(NUM_IN - 1);
        end else if (w_in_xfer) begin
            r_ptr <= w_grant;
        end
    end
`else
    assign w_grant = sel;
`endif

    // The register can take a new word if it is empty or drains this edge.
    // rst_n gates in_ready so nothing looks acceptable while in reset.
    assign w_accept  = rst_n && (!r_out_valid || out_ready);
    assign w_onehot  = NUM_IN'(1) << w_grant;
    assign in_ready  = w_accept ? w_onehot : '0;
    assign w_in_xfer = w_accept && in_valid[w_grant];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_grant*WIDTH +: WIDTH];
            r_out_src   <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_rr_mux_pipe.sv
module tb_rr_mux_pipe;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_src;

    int checks = 0;
    int errors = 0;
    int n_in   = 0;
    int n_out  = 0;

    // Reference model: the contents of the output register and the last grant.
    bit          m_valid;
    logic [31:0] m_data;
    int          m_src;
    int          m_ptr;

    rr_mux_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_ptr   = NUM_IN - 1;
    endtask

    function automatic int model_grant();
`ifdef RR_MUX_RR_ARB_EN
        int c;
        for (int off = 1; off <= NUM_IN; off++) begin
            c = (m_ptr + off) % NUM_IN;
            if (in_valid[c]) return c;
        end
        return (m_ptr + 1) % NUM_IN;
`else
        return int'(sel);
`endif
    endfunction

    // One clock: check the combinational handshake, take the edge, then
    // advance the model and compare the registered outputs.
    task automatic step();
        int                g;
        logic [NUM_IN-1:0] er;
        bit                ix;
        logic [WIDTH-1:0]  nd;
        #1;
        g  = model_grant();
        er = (!m_valid || out_ready) ? (NUM_IN'(1) << g) : '0;
        chk("in_ready", in_ready, er);
        ix = in_valid[g] && (er != '0);
        nd = in_data[g*WIDTH +: WIDTH];
        if (out_valid && out_ready) n_out++;
        @(posedge clk);
        #1;
        if (ix) begin
            m_valid = 1'b1;
            m_data  = nd;
            m_src   = g;
            m_ptr   = g;
            n_in++;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_src", out_src, m_src);
    endtask

    task automatic rand_data();
        for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = $urandom;
    endtask

    initial begin
        int b_in, b_out, guard;
        logic [WIDTH-1:0] ch2;

        rst_n     = 1'b0;
        in_valid  = '1;
        out_ready = 1'b1;
        sel       = '0;
        rand_data();
        model_reset();
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_src", out_src, 2'd0);
        chk("rst_in_ready", in_ready, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef RR_MUX_RR_ARB_EN
        in_valid  = '1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            step();
            chk("rr_seq", out_src, 2'(i % NUM_IN));
        end
        in_valid = 4'b1010;
        step();
        chk("rr_wrap_1", out_src, 2'd1);
        step();
        chk("rr_wrap_3", out_src, 2'd3);
        step();
        chk("rr_wrap_1b", out_src, 2'd1);
`else
        sel       = 2'd2;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        in_data[2*WIDTH +: WIDTH] = 32'hA5A5_A5A5;
        step();
        chk("fix_valid", out_valid, 1'b1);
        chk("fix_data", out_data, 32'hA5A5_A5A5);
        chk("fix_src", out_src, 2'd2);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            sel = 2'($urandom);
            step();
            chk("bp_ready", in_ready, 4'b0000);
            chk("bp_hold", out_data, 32'hA5A5_A5A5);
        end
        sel       = 2'd2;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            ch2 = in_data[2*WIDTH +: WIDTH];
            step();
            chk("b2b_valid", out_valid, 1'b1);
            chk("b2b_data", out_data, ch2);
        end
`endif

        // Asynchronous reset in the middle of a held word.
        sel       = '0;
        in_valid  = '1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        chk("pre_rst_valid", out_valid, 1'b1);
        #4;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_ready", in_ready, 4'b0000);
        #2;
        rst_n = 1'b1;
        model_reset();
        in_valid  = '1;
        out_ready = 1'b1;
        rand_data();
        step();
        chk("first_grant", out_src, 2'd0);

        in_valid = '0;
        step();
        b_in  = n_in;
        b_out = n_out;
        guard = 0;
        while ((n_in - b_in) < 100 && guard < 4000) begin
            rand_data();
            in_valid  = NUM_IN'($urandom);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            guard++;
        end
        in_valid  = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("words_in", n_in - b_in, 100);
        chk("words_out", n_out - b_out, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
